// File: rtl/counter_sched_if.sv
// +----------------------------------------------------------------------------+
// | counter_sched_if : request/terminal-count inputs and grant/count outputs   |
// | of the shared-counter scheduler.                                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface counter_sched_if #(
  parameter int WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] tc0;
  logic [WIDTH-1:0] tc1;
  logic [1:0]       grant;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic [1:0]       done;

  modport master (
    output req, tc0, tc1,
    input  grant, busy, count, done
  );

  modport slave (
    input  req, tc0, tc1,
    output grant, busy, count, done
  );
endinterface

`default_nettype wire

// File: rtl/counter_sched.sv
// +----------------------------------------------------------------------------+
// | counter_sched : round-robin arbiter for two requesters sharing one counter |
// | that runs from 0 up to the granted requester's terminal count.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module counter_sched #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  counter_sched_if.slave  bus
);

  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_tc_lat;
  logic [WIDTH-1:0] w_tc_lat_nxt;
  logic             r_owner;
  logic             w_owner_nxt;
  logic             r_last_owner;
  logic             w_last_owner_nxt;
  logic             w_winner;
  logic [1:0]       w_owner_onehot;
  logic [1:0]       w_grant;
  logic [1:0]       w_done;

  // Reset value of last_owner = 1 makes requester 0 win the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_tc_lat     <= '0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_tc_lat     <= w_tc_lat_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
    end
  end

  assign w_winner = (bus.req == 2'b11) ? ~r_last_owner : bus.req[1];

  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_tc_lat_nxt     = r_tc_lat;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_state_nxt  = RUN;
          w_owner_nxt  = w_winner;
          w_count_nxt  = '0;
          w_tc_lat_nxt = w_winner ? bus.tc1 : bus.tc0;
        end
      end
      RUN: begin
        // Terminal count reached: hold the count, so it can never wrap.
        if (r_count == r_tc_lat) begin
          w_state_nxt = DONE;
        end else begin
          w_count_nxt = r_count + c_one;
        end
      end
      DONE: begin
        w_state_nxt      = IDLE;
        w_last_owner_nxt = r_owner;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_owner_onehot = r_owner ? 2'b10 : 2'b01;
  assign w_grant = ((r_state == RUN) || (r_state == DONE)) ? w_owner_onehot : 2'b00;
  assign w_done  = (r_state == DONE) ? w_owner_onehot : 2'b00;

  assign bus.grant = w_grant;
  assign bus.busy  = |w_grant;
  assign bus.count = r_count;
  assign bus.done  = w_done;

endmodule

`default_nettype wire
